// File: rtl/lcd_seq.sv
// HD44780 command/character sequencer: issues the init sequence after power-up,
// then mirrors a 2x16 character buffer onto the display one byte per handshake.
module lcd_seq #(
  parameter int unsigned POWERUP_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_we,
  input  logic [4:0] char_addr,
  input  logic [7:0] char_data,
  input  logic       refresh,
  output logic       busy,
  output logic [7:0] ctrl_din,
  output logic       ctrl_regsel,
  output logic       ctrl_activate,
  input  logic       ctrl_ready
);

  typedef enum logic [2:0] {POWERUP, PREP, ISSUE, WAIT, IDLE} state_t;
  typedef enum logic {INIT, FRAME} mode_t;

  state_t      state;
  mode_t       mode;
  logic [31:0] timer;
  logic [5:0]  step;
  logic        dirty;
  logic [7:0]  char_buf [32];

  mode_t       load_mode;
  logic [5:0]  load_step;
  logic [4:0]  load_addr;
  logic [7:0]  load_din;
  logic        load_regsel;
  logic        last_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) char_buf[i] <= 8'h20;
    end else if (char_we) begin
      char_buf[char_addr] <= char_data;
    end
  end

  // Byte for the step about to be entered; buffer is read at PREP entry.
  always_comb begin
    load_mode = mode;
    load_step = step + 6'd1;
    if (state == POWERUP) begin
      load_mode = INIT;
      load_step = '0;
    end else if (state == IDLE) begin
      load_mode = FRAME;
      load_step = '0;
    end
    load_addr   = (load_step > 6'd17) ? 5'(load_step - 6'd2) : 5'(load_step - 6'd1);
    load_din    = 8'h00;
    load_regsel = 1'b0;
    if (load_mode == INIT) begin
      case (load_step)
        6'd0:    load_din = 8'h38;
        6'd1:    load_din = 8'h0C;
        6'd2:    load_din = 8'h01;
        default: load_din = 8'h06;
      endcase
    end else if (load_step == 6'd0) begin
      load_din = 8'h80;
    end else if (load_step == 6'd17) begin
      load_din = 8'hC0;
    end else begin
      load_din    = char_buf[load_addr];
      load_regsel = 1'b1;
    end
  end

  assign last_step = (mode == INIT) ? (step == 6'd3) : (step == 6'd33);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= POWERUP;
      mode          <= INIT;
      timer         <= '0;
      step          <= '0;
      dirty         <= 1'b1;
      busy          <= 1'b1;
      ctrl_din      <= 8'h00;
      ctrl_regsel   <= 1'b0;
      ctrl_activate <= 1'b0;
    end else begin
      if (char_we || refresh)
        dirty <= 1'b1;
      else if (state == IDLE && dirty)
        dirty <= 1'b0;

      case (state)
        POWERUP: begin
          if (timer == POWERUP_CYCLES - 1) begin
            state       <= PREP;
            mode        <= load_mode;
            step        <= load_step;
            ctrl_din    <= load_din;
            ctrl_regsel <= load_regsel;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        PREP: begin
          if (ctrl_ready) begin
            state         <= ISSUE;
            ctrl_activate <= 1'b1;
          end
        end
        ISSUE: begin
          if (!ctrl_ready) begin
            state         <= WAIT;
            ctrl_activate <= 1'b0;
          end
        end
        WAIT: begin
          if (ctrl_ready) begin
            if (last_step) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state       <= PREP;
              step        <= load_step;
              ctrl_din    <= load_din;
              ctrl_regsel <= load_regsel;
            end
          end
        end
        IDLE: begin
          if (dirty) begin
            state       <= PREP;
            mode        <= load_mode;
            step        <= load_step;
            busy        <= 1'b1;
            ctrl_din    <= load_din;
            ctrl_regsel <= load_regsel;
          end
        end
        default: state <= POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_seq.sv
// Self-checking bench for lcd_seq: controller model plus a transaction-level
// model of the expected init/frame byte stream.
module tb_lcd_seq;
  localparam int unsigned PC = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       char_we = 1'b0;
  logic [4:0] char_addr = '0;
  logic [7:0] char_data = '0;
  logic       refresh = 1'b0;
  logic       busy;
  logic [7:0] ctrl_din;
  logic       ctrl_regsel;
  logic       ctrl_activate;
  logic       ctrl_ready = 1'b1;

  lcd_seq #(.POWERUP_CYCLES(PC)) dut (
    .clk(clk), .reset(reset), .char_we(char_we), .char_addr(char_addr),
    .char_data(char_data), .refresh(refresh), .busy(busy), .ctrl_din(ctrl_din),
    .ctrl_regsel(ctrl_regsel), .ctrl_activate(ctrl_activate), .ctrl_ready(ctrl_ready)
  );

  always #5 clk = ~clk;

  // Controller: ready drops one cycle after an activate edge, returns after lat cycles.
  int unsigned lat = 20;
  int          ctl_cnt = 0;
  logic        act_seen = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) ctrl_ready = 1'b1;
    end else if (ctrl_activate && !act_seen) begin
      ctrl_ready = 1'b0;
      ctl_cnt = lat;
    end
    act_seen = ctrl_activate;
  end

  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc = 0;
    else cyc++;
  end

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] mbuf [32];
  logic [8:0] seen [34];
  logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int init_pos, fpos, frames_due, first_rise;
  logic p_act = 1'b0, p_ready = 1'b1, p_rst = 1'b1, p_regsel = 1'b0;
  logic [7:0] p_din = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Frame position k: 0 and 17 are line-address commands, the rest are characters.
  function automatic logic [8:0] frame_byte(input int k);
    int line, col;
    if (k == 0) return 9'h080;
    if (k == 17) return 9'h0C0;
    line = (k > 17) ? 1 : 0;
    col = k - 1 - 17 * line;
    return {1'b1, mbuf[line * 16 + col]};
  endfunction

  task automatic compare();
    logic [8:0] b;
    b = {ctrl_regsel, ctrl_din};
    if (!reset && !p_rst) begin
      if (ctrl_activate && !p_act) begin
        if (init_pos < 4) begin
          chk("init_byte", b, {1'b0, init_tab[init_pos]});
          if (init_pos == 0) first_rise = cyc;
          init_pos++;
        end else if (frames_due > 0) begin
          chk("frame_byte", b, frame_byte(fpos));
          seen[fpos] = b;
          fpos++;
          if (fpos == 34) begin
            fpos = 0;
            frames_due--;
          end
        end else begin
          chk("unexpected_tx", b, 9'h1FF);
        end
      end
      if (p_act || !p_ready) chk("hold_din", b, {p_regsel, p_din});
      if (!p_ready) chk("act_low_after_ready_low", ctrl_activate, 1'b0);
    end
    p_act = ctrl_activate;
    p_ready = ctrl_ready;
    p_rst = reset;
    p_regsel = ctrl_regsel;
    p_din = ctrl_din;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    init_pos = 0;
    fpos = 0;
    frames_due = 1;
    first_rise = -1;
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] d, input logic refr);
    char_we = 1'b1;
    char_addr = a;
    char_data = d;
    refresh = refr;
    mbuf[a] = d;
    tick();
    char_we = 1'b0;
    refresh = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(init_pos == 4 && frames_due == 0 && !busy) && n < 20000) begin
      tick();
      n++;
    end
    chk(name, 32'(n < 20000), 32'd1);
  endtask

  task automatic wait_fpos(input int target);
    int n;
    n = 0;
    while (fpos < target && n < 5000) begin
      tick();
      n++;
    end
    chk("reach_step", 32'(n < 5000), 32'd1);
  endtask

  task automatic quiet(input string name, input int cycles);
    int nb;
    nb = 0;
    repeat (cycles) begin
      tick();
      if (busy) nb++;
    end
    chk(name, nb, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, nw;
    model_reset();
    repeat (3) tick();
    chk("reset_busy", busy, 1'b1);
    chk("reset_din", ctrl_din, 8'h00);
    chk("reset_regsel", ctrl_regsel, 1'b0);
    chk("reset_activate", ctrl_activate, 1'b0);
    reset = 1'b0;

    // Power-up, init and the first (dirty-at-reset) frame of spaces.
    wait_idle("t1_done");
    chk("t1_first_rise", first_rise, 11);
    chk("t1_step0", seen[0], 9'h080);
    chk("t1_step17", seen[17], 9'h0C0);
    chk("t1_step5", seen[5], 9'h120);
    quiet("t1_quiet", 500);

    // Two back-to-back writes: second lands on the idle-exit cycle, so two frames.
    frames_due += 2;
    write_char(5'd0, 8'h48, 1'b0);
    write_char(5'd17, 8'h69, 1'b0);
    wait_idle("t2_done");
    chk("t2_step1", seen[1], 9'h148);
    chk("t2_step19", seen[19], 9'h169);
    chk("t2_step2", seen[2], 9'h120);
    quiet("t2_quiet", 50);

    // Write during frame step 5 forces a following frame.
    frames_due += 1;
    write_char(5'd2, 8'h33, 1'b0);
    wait_fpos(5);
    frames_due += 1;
    write_char(5'd31, 8'h41, 1'b0);
    wait_idle("t3_done");
    chk("t3_step33", seen[33], 9'h141);
    quiet("t3_quiet", 50);

    // Controller stalls for 1000 cycles on step 10.
    frames_due += 1;
    write_char(5'd9, 8'h5A, 1'b0);
    wait_fpos(10);
    lat = 1000;
    wait_fpos(11);
    lat = 20;
    wait_idle("t4_done");
    chk("t4_step10", seen[10], 9'h15A);
    quiet("t4_quiet", 50);

    // char_we then char_we+refresh on the idle-exit cycle -> exactly two frames.
    frames_due += 2;
    write_char(5'd5, 8'h55, 1'b0);
    write_char(5'd6, 8'h66, 1'b1);
    wait_idle("t6_done");
    chk("t6_step7", seen[7], 9'h166);
    quiet("t6_quiet", 200);

    // Randomized bursts of writes with random controller latency.
    for (int r = 0; r < 4; r++) begin
      lat = $urandom_range(2, 30);
      nw = $urandom_range(1, 3);
      frames_due += (nw == 1) ? 1 : 2;
      for (int w = 0; w < nw; w++)
        write_char(5'($urandom_range(0, 31)), 8'($urandom_range(32, 126)), 1'b0);
      wait_idle("rand_done");
      quiet("rand_quiet", 30);
    end
    lat = 20;

    // Reset during frame step 20.
    frames_due += 1;
    write_char(5'd20, 8'h77, 1'b0);
    wait_fpos(20);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_busy", busy, 1'b1);
    chk("t5_din", ctrl_din, 8'h00);
    chk("t5_regsel", ctrl_regsel, 1'b0);
    chk("t5_activate", ctrl_activate, 1'b0);
    model_reset();
    n = 0;
    while (!ctrl_ready && n < 2000) begin
      tick();
      n++;
    end
    tick();
    reset = 1'b0;
    wait_idle("t5_done");
    chk("t5_first_rise", first_rise, 11);
    chk("t5_step19", seen[19], 9'h120);
    chk("t5_step1", seen[1], 9'h120);
    quiet("t5_quiet", 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
